// File: rtl/alu_iter_shifter.sv
// rtl/alu_iter_shifter.sv - multi-cycle one-bit-per-clock shift/rotate unit
module alu_iter_shifter #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 8,
  parameter int FLAGS_W = 4
) (
  input  logic               master_clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic               pair,
  input  logic [WIDTH-1:0]   a_in_lo,
  input  logic [WIDTH-1:0]   a_in_hi,
  input  logic [CNT_W-1:0]   b_in,
  input  logic [FLAGS_W-1:0] proc_flags_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out_lo,
  output logic [WIDTH-1:0]   out_hi,
  output logic [FLAGS_W-1:0] proc_flags_out
);

  localparam int PF_SLOT_Z = 0;
  localparam int PF_SLOT_C = 1;
  localparam int PF_SLOT_N = 3;

  localparam logic [2:0] OP_LSL  = 3'd0;
  localparam logic [2:0] OP_LSR  = 3'd1;
  localparam logic [2:0] OP_ASR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ROLC = 3'd5;
  localparam logic [2:0] OP_RORC = 3'd6;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]           r_state;
  logic [2:0]           r_op;
  logic                 r_pair;
  logic [2*WIDTH-1:0]   r_work;
  logic                 r_c;
  logic [CNT_W-1:0]     r_n;
  logic [FLAGS_W-1:0]   r_flags;
  logic                 r_done;
  logic [WIDTH-1:0]     r_out_lo;
  logic [WIDTH-1:0]     r_out_hi;
  logic [FLAGS_W-1:0]   r_flags_out;

  logic [CNT_W-1:0]     w_lim;
  logic [CNT_W-1:0]     w_n_start;
  logic                 w_msb;
  logic                 w_lsb;
  logic                 w_in;
  logic                 w_left;
  logic                 w_c_nxt;
  logic [2*WIDTH-1:0]   w_step;
  logic [FLAGS_W-1:0]   w_flags_nxt;

  // Shifts saturate one past the operand width so a full flush also clears C.
  always_comb begin
    w_lim     = pair ? CNT_W'(2*WIDTH+1) : CNT_W'(WIDTH+1);
    w_n_start = '0;
    case (op)
      OP_LSL, OP_LSR, OP_ASR:            w_n_start = (b_in > w_lim) ? w_lim : b_in;
      OP_ROL, OP_ROR, OP_ROLC, OP_RORC:  w_n_start = b_in & CNT_W'(WIDTH-1);
      default:                           w_n_start = '0;
    endcase
  end

  always_comb begin
    w_msb   = r_pair ? r_work[2*WIDTH-1] : r_work[WIDTH-1];
    w_lsb   = r_work[0];
    w_in    = 1'b0;
    w_left  = 1'b1;
    w_c_nxt = w_msb;
    case (r_op)
      OP_LSL:  begin w_in = 1'b0;  w_left = 1'b1; w_c_nxt = w_msb; end
      OP_LSR:  begin w_in = 1'b0;  w_left = 1'b0; w_c_nxt = w_lsb; end
      OP_ASR:  begin w_in = w_msb; w_left = 1'b0; w_c_nxt = w_lsb; end
      OP_ROL:  begin w_in = w_msb; w_left = 1'b1; w_c_nxt = w_msb; end
      OP_ROR:  begin w_in = w_lsb; w_left = 1'b0; w_c_nxt = w_lsb; end
      OP_ROLC: begin w_in = r_c;   w_left = 1'b1; w_c_nxt = w_msb; end
      OP_RORC: begin w_in = r_c;   w_left = 1'b0; w_c_nxt = w_lsb; end
      default: begin w_in = 1'b0;  w_left = 1'b1; w_c_nxt = r_c;   end
    endcase
    // Single-width ops leave the latched high half untouched.
    if (r_pair)
      w_step = w_left ? {r_work[2*WIDTH-2:0], w_in} : {w_in, r_work[2*WIDTH-1:1]};
    else
      w_step = w_left ? {r_work[2*WIDTH-1:WIDTH], r_work[WIDTH-2:0], w_in}
                      : {r_work[2*WIDTH-1:WIDTH], w_in, r_work[WIDTH-1:1]};
  end

  always_comb begin
    w_flags_nxt            = r_flags;
    w_flags_nxt[PF_SLOT_Z] = r_pair ? (r_work == '0) : (r_work[WIDTH-1:0] == '0);
    w_flags_nxt[PF_SLOT_C] = r_c;
    w_flags_nxt[PF_SLOT_N] = w_msb;
  end

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_pair      <= 1'b0;
      r_work      <= '0;
      r_c         <= 1'b0;
      r_n         <= '0;
      r_flags     <= '0;
      r_done      <= 1'b0;
      r_out_lo    <= '0;
      r_out_hi    <= '0;
      r_flags_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_pair  <= pair;
            r_work  <= {a_in_hi, a_in_lo};
            r_c     <= proc_flags_in[PF_SLOT_C];
            r_flags <= proc_flags_in;
            r_n     <= w_n_start;
            r_state <= S_RUN;
          end
        end
        default: begin
          if (r_n != '0) begin
            r_work <= w_step;
            r_c    <= w_c_nxt;
            r_n    <= r_n - 1'b1;
          end else begin
            r_out_lo    <= r_work[WIDTH-1:0];
            r_out_hi    <= r_work[2*WIDTH-1:WIDTH];
            r_flags_out <= w_flags_nxt;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy           = (r_state == S_RUN);
  assign done           = r_done;
  assign out_lo         = r_out_lo;
  assign out_hi         = r_out_hi;
  assign proc_flags_out = r_flags_out;

endmodule
